// File: rtl/conv_enc.sv
// Rate-1/2, K=3 convolutional encoder. It takes one DATA_W-bit frame MSB-first and emits a 2*DATA_W-bit codeword.
// Timing: the frame is accepted on E0, one bit is coded per edge on E1..E(DATA_W), and valid pulses for one cycle after E(DATA_W).
module conv_enc #(
    parameter int         DATA_W = 8,
    parameter logic [2:0] G0     = 3'b111,
    parameter logic [2:0] G1     = 3'b101
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_W-1:0]     data_in,
    output logic                  ready,
    output logic                  valid,
    output logic [2*DATA_W-1:0]   data_out
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            s_q, s_d;       // {s1, s0}
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     msg_q, msg_d;
    logic [2*DATA_W-3:0]   cw_q, cw_d;
    logic [2*DATA_W-1:0]   dout_q, dout_d;

    logic                  u, c0, c1;
    logic [CNT_W-1:0]      idx;
    logic [2*DATA_W-1:0]   cw_shift;

    assign idx      = LAST - cnt_q;
    assign u        = msg_q[idx];
    assign c0       = ^({u, s_q} & G0);
    assign c1       = ^({u, s_q} & G1);
    // Pairs are shifted in at the bottom, so after DATA_W bits the first pair sits in the top two bits.
    assign cw_shift = {cw_q, c0, c1};

    assign ready    = (state_q == IDLE);
    assign valid    = (state_q == DONE);
    assign data_out = dout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            cnt_q   <= '0;
            msg_q   <= '0;
            cw_q    <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            msg_q   <= msg_d;
            cw_q    <= cw_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        msg_d   = msg_q;
        cw_d    = cw_q;
        dout_d  = dout_q;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    msg_d   = data_in;
                    s_d     = '0;
                    cnt_d   = '0;
                    cw_d    = '0;
                    state_d = ENC;
                end
            end
            ENC: begin
                s_d   = {u, s_q[1]};
                cnt_d = cnt_q + CNT_W'(1);
                cw_d  = cw_shift[2*DATA_W-3:0];
                if (cnt_q == LAST) begin
                    dout_d  = cw_shift;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_conv_enc.sv
// Directed bench for conv_enc. Each test task drives its stimulus and compares the outputs against hand-computed codewords.
module tb_conv_enc;

    logic        clk;
    logic        rst;
    logic        en;
    logic [7:0]  data_in;
    logic        ready;
    logic        valid;
    logic [15:0] data_out;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    conv_enc #(.DATA_W(8), .G0(3'b111), .G1(3'b101)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .data_in  (data_in),
        .ready    (ready),
        .valid    (valid),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requests one frame from idle and waits up to 20 edges for valid.
    // lat is -1 if valid never appeared.
    task automatic send_frame(input logic [7:0] d, output int lat, output logic [15:0] cw);
        lat = -1;
        cw  = 'x;
        en      = 1'b1;
        data_in = d;
        tick();
        en = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (valid) begin
                lat = i;
                cw  = data_out;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int pulses;
        rst = 1'b1; en = 1'b0; data_in = 8'h00;
        tick(); tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", ready); end
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", valid); end
        n_cmp++; if (data_out !== 16'h0000) begin n_err++; $display("FAIL reset_dout got=%h exp=0000", data_out); end
        // Abort a frame after four coded bits.
        en = 1'b1; data_in = 8'hFF;
        tick();
        en = 1'b0;
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL accept_ready got=%b exp=0", ready); end
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready got=%b exp=1", ready); end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (valid) pulses++;
            tick();
        end
        n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL midrst_no_valid got=%0d pulses exp=0", pulses); end
        n_cmp++; if (data_out !== 16'h0000) begin n_err++; $display("FAIL midrst_dout got=%h exp=0000", data_out); end
    endtask

    task automatic test_single_80();
        int lat; logic [15:0] cw;
        send_frame(8'h80, lat, cw);
        n_cmp++; if (lat != 8) begin n_err++; $display("FAIL lat_80 got=%0d exp=8", lat); end
        n_cmp++; if (cw !== 16'hEC00) begin n_err++; $display("FAIL cw_80 got=%h exp=ec00", cw); end
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL done_ready got=%b exp=0", ready); end
        tick();
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL valid_width got=%b exp=0", valid); end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL post_ready got=%b exp=1", ready); end
        n_cmp++; if (data_out !== 16'hEC00) begin n_err++; $display("FAIL hold_80 got=%h exp=ec00", data_out); end
    endtask

    task automatic test_patterns();
        logic [7:0]  din [4] = '{8'hFF, 8'h00, 8'h01, 8'hA5};
        logic [15:0] exp [4] = '{16'hDAAA, 16'h0000, 16'h0003, 16'hE2F8};
        int lat; logic [15:0] cw;
        for (int k = 0; k < 4; k++) begin
            send_frame(din[k], lat, cw);
            tick();
            n_cmp++;
            if (lat != 8 || cw !== exp[k]) begin
                n_err++;
                $display("FAIL pattern_%h got=%h lat=%0d exp=%h lat=8", din[k], cw, lat, exp[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t [$];
        int bad_cw;
        en = 1'b1; data_in = 8'h80;
        bad_cw = 0;
        for (int i = 0; i < 35; i++) begin
            tick();
            if (valid) begin
                t.push_back(cyc);
                if (data_out !== 16'hEC00) bad_cw++;
            end
        end
        en = 1'b0;
        n_cmp++; if (t.size() != 3) begin n_err++; $display("FAIL b2b_count got=%0d exp=3", t.size()); end
        n_cmp++; if (bad_cw != 0) begin n_err++; $display("FAIL b2b_cw got=%0d bad exp=0", bad_cw); end
        if (t.size() >= 3) begin
            n_cmp++;
            if (t[1] - t[0] != 10 || t[2] - t[1] != 10) begin
                n_err++;
                $display("FAIL b2b_period got=%0d,%0d exp=10,10", t[1] - t[0], t[2] - t[1]);
            end
        end
        while (!ready) tick();
    endtask

    task automatic test_data_change();
        int lat;
        en = 1'b1; data_in = 8'hA5;
        tick();
        en = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            data_in = 8'(i * 37);
            tick();
            if (valid) begin lat = i; break; end
        end
        n_cmp++; if (lat != 8) begin n_err++; $display("FAIL chg_lat got=%0d exp=8", lat); end
        n_cmp++; if (data_out !== 16'hE2F8) begin n_err++; $display("FAIL chg_cw got=%h exp=e2f8", data_out); end
        tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; data_in = 8'h00;
        test_reset();
        test_single_80();
        test_patterns();
        test_back_to_back();
        test_data_change();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
